// File: rtl/lb_arbiter.sv
// ---------------------------------------------------------------------------
// lb_arbiter
// Two-requester local-bus arbiter. Requester 0 and requester 1 each present
// independent write and read request channels. A single transaction at a time
// is forwarded to the shared bus. When both requesters ask at the same moment,
// the one that was not served last gets the bus.
//
// Optional feature macro: LB_ARB_TIMEOUT_EN
//   defined   : an access left unanswered for TIMEOUT_CYCLES cycles is aborted.
//               The requester receives a completion (read data 0), and
//               timeout_err pulses for one cycle.
//   undefined : accesses wait indefinitely, and timeout_err is tied low.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous, active-low reset
//   mN_waddr/wdata/wstrb     requester N write address, data, byte strobes
//   mN_wen / mN_wready       requester N write request / completion
//   mN_raddr / mN_ren        requester N read address / request
//   mN_rdata / mN_rvalid     requester N read data / completion
//   s_waddr/wdata/wstrb      shared-bus write fields (0 unless writing)
//   s_raddr                  shared-bus read address (0 unless reading)
//   s_wen / s_ren            shared-bus write / read request
//   s_wready / s_rvalid      shared-bus write completion / read data valid
//   s_rdata                  shared-bus read data
//   timeout_err              one-cycle pulse when an access is aborted
// ---------------------------------------------------------------------------
module lb_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     m0_waddr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wen,
    output logic                  m0_wready,
    input  logic [ADDR_W-1:0]     m0_raddr,
    input  logic                  m0_ren,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_rvalid,
    input  logic [ADDR_W-1:0]     m1_waddr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wen,
    output logic                  m1_wready,
    input  logic [ADDR_W-1:0]     m1_raddr,
    input  logic                  m1_ren,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_rvalid,
    output logic [ADDR_W-1:0]     s_waddr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic [ADDR_W-1:0]     s_raddr,
    output logic                  s_wen,
    output logic                  s_ren,
    input  logic                  s_wready,
    input  logic                  s_rvalid,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   gnt_r;          // requester owning the current transaction
    logic   gnt_nxt_s;
    logic   last_r;         // requester served most recently
    logic   last_nxt_s;
    logic   req0_s;
    logic   req1_s;
    logic   sel_s;
    logic   to_hit_s;       // access has run out of time this cycle

`ifdef LB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_r;

    // Access-age counter: held at zero in IDLE, so it restarts on every entry
    // to WR/RD and counts the cycles spent waiting there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + CNT_W'(1);
        end
    end

    assign to_hit_s = (to_cnt_r == CNT_W'(TIMEOUT_CYCLES));
`else
    assign to_hit_s = 1'b0;
`endif

    assign req0_s = m0_wen | m0_ren;
    assign req1_s = m1_wen | m1_ren;

    // Round-robin choice: a tie goes to the requester not served last.
    always_comb begin
        sel_s = 1'b0;
        if (req0_s && req1_s) begin
            sel_s = ~last_r;
        end else if (req1_s) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // State, grant and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next state plus all bus/requester outputs. The outputs follow the state
    // directly: after a reset the FSM is IDLE, so every output is 0.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        last_nxt_s  = last_r;
        s_waddr     = {ADDR_W{1'b0}};
        s_wdata     = {DATA_W{1'b0}};
        s_wstrb     = {(DATA_W/8){1'b0}};
        s_raddr     = {ADDR_W{1'b0}};
        s_wen       = 1'b0;
        s_ren       = 1'b0;
        m0_wready   = 1'b0;
        m1_wready   = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        m0_rdata    = {DATA_W{1'b0}};
        m1_rdata    = {DATA_W{1'b0}};
        timeout_err = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    gnt_nxt_s = sel_s;
                    // A requester asking for both is given its write first.
                    if (sel_s ? m1_wen : m0_wen) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_WR: begin
                if (to_hit_s) begin
                    // Abort: bus request already dropped, complete locally.
                    timeout_err = 1'b1;
                    if (gnt_r) begin
                        m1_wready = 1'b1;
                    end else begin
                        m0_wready = 1'b1;
                    end
                    last_nxt_s  = gnt_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    s_wen   = 1'b1;
                    s_waddr = gnt_r ? m1_waddr : m0_waddr;
                    s_wdata = gnt_r ? m1_wdata : m0_wdata;
                    s_wstrb = gnt_r ? m1_wstrb : m0_wstrb;
                    if (gnt_r) begin
                        m1_wready = s_wready;
                    end else begin
                        m0_wready = s_wready;
                    end
                    if (s_wready) begin
                        last_nxt_s  = gnt_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WR;
                    end
                end
            end

            ST_RD: begin
                if (to_hit_s) begin
                    // Abort: completion carries zero data.
                    timeout_err = 1'b1;
                    if (gnt_r) begin
                        m1_rvalid = 1'b1;
                    end else begin
                        m0_rvalid = 1'b1;
                    end
                    last_nxt_s  = gnt_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    s_ren   = 1'b1;
                    s_raddr = gnt_r ? m1_raddr : m0_raddr;
                    if (gnt_r) begin
                        m1_rvalid = s_rvalid;
                        m1_rdata  = s_rdata;
                    end else begin
                        m0_rvalid = s_rvalid;
                        m0_rdata  = s_rdata;
                    end
                    if (s_rvalid) begin
                        last_nxt_s  = gnt_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lb_arbiter
// Self-checking bench for lb_arbiter. The bench plays both requesters and the
// shared-bus target. A transaction-level model predicts which requester is
// served next (round-robin over pending requests, write before read) and what
// must appear on every port in each cycle. A small memory model supplies the
// read data and absorbs strobed writes. If LB_ARB_TIMEOUT_EN is defined, the
// timeout scenario expects an abort; otherwise it expects an indefinite wait.
// ---------------------------------------------------------------------------
module tb_lb_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [AW-1:0]   waddr [2];
    logic [DW-1:0]   wdata [2];
    logic [SW-1:0]   wstrb [2];
    logic [AW-1:0]   raddr [2];
    logic            wen   [2];
    logic            ren   [2];
    logic            m0_wready, m1_wready, m0_rvalid, m1_rvalid;
    logic [DW-1:0]   m0_rdata, m1_rdata;
    logic [AW-1:0]   s_waddr, s_raddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_wen, s_ren, s_wready, s_rvalid, timeout_err;

    lb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_waddr(waddr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wen(wen[0]),
        .m0_wready(m0_wready), .m0_raddr(raddr[0]), .m0_ren(ren[0]),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_waddr(waddr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wen(wen[1]),
        .m1_wready(m1_wready), .m1_raddr(raddr[1]), .m1_ren(ren[1]),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_raddr(s_raddr),
        .s_wen(s_wen), .s_ren(s_ren), .s_wready(s_wready), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int last_srv;                       // model: requester served most recently
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'h5a5a, a};
    endfunction

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] cur;
        cur = rd_val(a);
        for (int b = 0; b < SW; b++) begin
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        mem[a] = cur;
    endtask

    // Idle cycle: the target throws stray handshakes, which must be ignored.
    task automatic check_idle(input string tag);
        s_wready = 1'($urandom);
        s_rvalid = 1'($urandom);
        s_rdata  = $urandom;
        #1;
        check_eq({tag, "_ctl"}, 128'({s_wen, s_ren, m0_wready, m1_wready, m0_rvalid, m1_rvalid, timeout_err}), 128'd0);
        check_eq({tag, "_bus"}, 128'({s_waddr, s_wdata, s_wstrb, s_raddr}), 128'd0);
        check_eq({tag, "_rdata"}, 128'({m0_rdata, m1_rdata}), 128'd0);
    endtask

    // One arbitrated transaction, entered at posedge+1 of an idle cycle with the
    // requests already raised. The target answers after 'lat' wait cycles, unless
    // rst_mid asks for a reset in the last wait cycle instead.
    task automatic run_txn(input int lat, input bit rst_mid);
        int            g;
        bit            is_wr, done, p0, p1;
        logic [DW-1:0] exp_rd, drv;
        p0 = wen[0] | ren[0];
        p1 = wen[1] | ren[1];
        g  = (p0 && p1) ? ((last_srv == 1) ? 0 : 1) : (p1 ? 1 : 0);
        is_wr  = wen[g];
        exp_rd = rd_val(raddr[g]);
        check_idle("req_idle");
        for (int c = 0; c <= lat; c++) begin
            @(posedge clk); #1;
            done     = (c == lat) && !rst_mid;
            s_wready = is_wr ? done : 1'($urandom);
            s_rvalid = !is_wr ? done : 1'($urandom);
            s_rdata  = done ? exp_rd : $urandom;
            drv      = s_rdata;
            if (rst_mid && c == lat) rst = 1'b0;
            #1;
            if (is_wr)
                check_eq("wr_bus", 128'({s_wen, s_ren, s_waddr, s_wdata, s_wstrb, s_raddr}),
                         128'({2'b10, waddr[g], wdata[g], wstrb[g], 16'h0000}));
            else
                check_eq("rd_bus", 128'({s_wen, s_ren, s_waddr, s_wdata, s_wstrb, s_raddr}),
                         128'({2'b01, 16'h0000, 32'h0, 4'h0, raddr[g]}));
            check_eq("handshake", 128'({m0_wready, m1_wready, m0_rvalid, m1_rvalid, timeout_err}),
                     128'({is_wr && done && g == 0, is_wr && done && g == 1,
                           !is_wr && done && g == 0, !is_wr && done && g == 1, 1'b0}));
            check_eq("rdata", 128'({m0_rdata, m1_rdata}),
                     128'({(!is_wr && g == 0) ? drv : 32'h0, (!is_wr && g == 1) ? drv : 32'h0}));
        end
        @(posedge clk); #1;
        s_wready = 1'b0;
        s_rvalid = 1'b0;
        if (rst_mid) begin
            rst      = 1'b1;
            last_srv = 1;
        end else begin
            last_srv = g;
            if (is_wr) begin
                mem_write(waddr[g], wdata[g], wstrb[g]);
                wen[g] = 1'b0;
            end else begin
                ren[g] = 1'b0;
            end
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            waddr[i] = '0; wdata[i] = '0; wstrb[i] = '0; raddr[i] = '0;
            wen[i] = 1'b0; ren[i] = 1'b0;
        end
        s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        rst = 1'b0;
        last_srv = 1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;

        // Single write from m0, immediate completion.
        wen[0] = 1'b1; waddr[0] = 16'h0004; wdata[0] = 32'hdeadbeef; wstrb[0] = 4'hf;
        run_txn(0, 1'b0);

        // Simultaneous m0 write and m1 read, served twice round-robin.
        mem[16'h0014] = 32'hc0debabe;
        for (int r = 0; r < 2; r++) begin
            wen[0] = 1'b1; waddr[0] = 16'h0010; wdata[0] = 32'h11223344 + r; wstrb[0] = 4'hf;
            ren[1] = 1'b1; raddr[1] = 16'h0014;
            run_txn(1, 1'b0);
            run_txn(2, 1'b0);
        end

        // m1 read with five wait cycles.
        mem[16'h0008] = 32'hdeadbeef;
        ren[1] = 1'b1; raddr[1] = 16'h0008;
        run_txn(5, 1'b0);

        // m0 partial-strobe write with five wait cycles.
        wen[0] = 1'b1; waddr[0] = 16'h000c; wdata[0] = 32'hcafebabe; wstrb[0] = 4'b0110;
        run_txn(5, 1'b0);

        // Reset in the middle of an m1 read; afterwards a tie must go to m0.
        ren[1] = 1'b1; raddr[1] = 16'h0020;
        run_txn(3, 1'b1);
        wen[0] = 1'b1; waddr[0] = 16'h0024; wdata[0] = 32'h0a0b0c0d; wstrb[0] = 4'hf;
        run_txn(1, 1'b0);
        run_txn(1, 1'b0);

        // m0 read that the target never answers.
        ren[0] = 1'b1; raddr[0] = 16'h0030;
        check_idle("to_idle");
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h12345678;
            #1;
            check_eq("to_wait", 128'({s_ren, m0_rvalid, timeout_err}), 128'(3'b100));
        end
        @(posedge clk); #2;
`ifdef LB_ARB_TIMEOUT_EN
        check_eq("to_fire", 128'({s_ren, m0_rvalid, m0_rdata, timeout_err}), 128'({1'b0, 1'b1, 32'h0, 1'b1}));
`else
        for (int c = 0; c < 20; c++) begin
            check_eq("to_hold", 128'({s_ren, m0_rvalid, m0_rdata, timeout_err}),
                     128'({1'b1, 1'b0, 32'h12345678, 1'b0}));
            @(posedge clk); #2;
        end
        s_rvalid = 1'b1; s_rdata = 32'h0badf00d;
        #1;
        check_eq("to_late_done", 128'({m0_rvalid, m0_rdata, timeout_err}), 128'({1'b1, 32'h0badf00d, 1'b0}));
`endif
        @(posedge clk); #1;
        ren[0] = 1'b0; s_rvalid = 1'b0;
        last_srv = 0;

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!wen[i] && !ren[i] && ($urandom % 3) != 0) begin
                    k        = int'($urandom % 3);
                    waddr[i] = 16'({$urandom_range(0, 15), 2'b00});
                    raddr[i] = 16'({$urandom_range(0, 15), 2'b00});
                    wdata[i] = $urandom;
                    wstrb[i] = 4'($urandom);
                    wen[i]   = (k != 1);
                    ren[i]   = (k != 0);
                end
            end
            if (wen[0] || ren[0] || wen[1] || ren[1]) begin
                run_txn(int'($urandom_range(0, 3)), 1'b0);
            end else begin
                check_idle("quiet");
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
